// File: rtl/spi_pkg.sv
// Shared types for the SPI main engine.
// Optional LSB-first support is enabled with SPI_MAIN_LSB_FIRST_EN.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period generator: down-counter that pulses tick_o at zero.
// Holds the counter loaded from div_i while disabled.
module spi_clk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (!en_i || tick_o) begin
            cnt_d = div_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_main_ctrl.sv
// SPI main engine: one full-duplex DATA_W-bit transfer per start, modes 0-3.
// Define SPI_MAIN_LSB_FIRST_EN to add the lsb_first port.
module spi_main_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W,
    parameter int DIV_W  = 8
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  clk_div,
`ifdef SPI_MAIN_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    input  logic              miso,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi
);

    localparam int EW = $clog2(2 * DATA_W) + 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    spi_state_e        state_q, state_d;
    spi_mode_t         mode_q, mode_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rxs_q, rxs_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic              sclk_q, sclk_d;
    logic              cs_n_q, cs_n_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              lsb_q, lsb_d;
    logic              lsb_in;
    logic              clk_en;
    logic              tick;
    logic [DATA_W-1:0] tx_sh;

`ifdef SPI_MAIN_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    function automatic logic head(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    assign clk_en = (state_q != IDLE);

    // div_d feeds the counter so a new divider applies from SETUP onward
    spi_clk_gen #(
        .DIV_W (DIV_W)
    ) u_clk_gen (
        .clk_i  (pclk),
        .rst_i  (preset),
        .en_i   (clk_en),
        .div_i  (div_d),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        div_d     = div_q;
        tx_d      = tx_q;
        rxs_d     = rxs_q;
        rx_data_d = rx_data_q;
        edge_d    = edge_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        lsb_d     = lsb_q;
        done_d    = 1'b0;
        tx_sh     = lsb_q ? (tx_q >> 1) : (tx_q << 1);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    tx_d    = tx_data;
                    rxs_d   = '0;
                    mode_d  = '{cpol: cpol, cpha: cpha};
                    div_d   = clk_div;
                    lsb_d   = lsb_in;
                    edge_d  = '0;
                    sclk_d  = cpol;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = cpha ? 1'b0 : head(tx_data, lsb_in);
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (tick) begin
                    edge_d = edge_q + 1'b1;
                    sclk_d = ~sclk_q;
                    // edge_q[0]==0 is a leading edge
                    if (edge_q[0] == mode_q.cpha) begin
                        rxs_d = lsb_q ? {miso, rxs_q[DATA_W-1:1]}
                                      : {rxs_q[DATA_W-2:0], miso};
                    end else if (edge_q != LAST_EDGE) begin
                        tx_d   = tx_sh;
                        mosi_d = mode_q.cpha ? head(tx_q, lsb_q)
                                             : head(tx_sh, lsb_q);
                    end
                    if (edge_q == LAST_EDGE) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d   = IDLE;
                    cs_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    sclk_d    = mode_q.cpol;
                    rx_data_d = rxs_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            div_q     <= '0;
            tx_q      <= '0;
            rxs_q     <= '0;
            rx_data_q <= '0;
            edge_q    <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lsb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            div_q     <= div_d;
            tx_q      <= tx_d;
            rxs_q     <= rxs_d;
            rx_data_q <= rx_data_d;
            edge_q    <= edge_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            lsb_q     <= lsb_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_main_ctrl.sv
// Self-checking bench for spi_main_ctrl with a mode-aware subordinate model.
// Honours SPI_MAIN_LSB_FIRST_EN when defined.
module tb_spi_main_ctrl;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic [7:0] clk_div = 8'h00;
    logic       lsb_first = 1'b0;
    logic       miso;
    logic       busy, done, sclk, cs_n, mosi;
    logic [7:0] rx_data;
    logic       loop_en = 1'b0;
    logic       sub_miso = 1'b0;

    int checks = 0;
    int errors = 0;

    assign miso = loop_en ? mosi : sub_miso;

    always #5 pclk = ~pclk;

    spi_main_ctrl #(
        .DATA_W (8),
        .DIV_W  (8)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .start     (start),
        .tx_data   (tx_data),
        .cpol      (cpol),
        .cpha      (cpha),
        .clk_div   (clk_div),
`ifdef SPI_MAIN_LSB_FIRST_EN
        .lsb_first (lsb_first),
`endif
        .miso      (miso),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi)
    );

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Bit the subordinate presents after e SCLK edges of the transfer.
    function automatic logic sub_bit(input logic [7:0] w, input int e,
                                     input logic ch, input logic lf);
        int idx;
        if (ch) idx = (e == 0) ? 0 : (e - 1) / 2;
        else    idx = e / 2;
        if (idx > 7) idx = 7;
        return lf ? w[idx] : w[7-idx];
    endfunction

    task automatic test_transfer(input logic [7:0] tx, input logic cp,
                                 input logic ch, input logic [7:0] dv,
                                 input logic [7:0] sw, input logic lp,
                                 input logic lf, input int disturb,
                                 input string tag);
        int cslow, edges, samp, bound, busy_bad, post_bad, exp_low;
        logic [7:0] mw, got_rx, exp_rx, exp_mw;
        logic prev_sclk, prev_cs, got_done, coinc, first_bit, idle_ok;
        cslow = 0; edges = 0; samp = 0; busy_bad = 0; post_bad = 0;
        mw = 8'h00; got_rx = 8'h00; got_done = 1'b0; coinc = 1'b1;
        first_bit = 1'b0; idle_ok = 1'b1;
        exp_low = 18 * (int'(dv) + 1);
        bound = 20 * (int'(dv) + 1) + 10;
        @(negedge pclk);
        tx_data = tx; cpol = cp; cpha = ch; clk_div = dv;
        lsb_first = lf; loop_en = lp;
        sub_miso = sub_bit(sw, 0, ch, lf);
        start = 1'b1;
        prev_sclk = sclk; prev_cs = cs_n;
        for (int c = 0; c < bound && !got_done; c++) begin
            @(posedge pclk); #1;
            if (c == 0) begin
                start = 1'b0;
                if (sclk !== cp || cs_n !== 1'b0) idle_ok = 1'b0;
            end
            if (c == disturb) begin
                tx_data = 8'hFF; cpol = ~cp; cpha = ~ch;
                clk_div = 8'h00; start = 1'b1;
            end
            if (c == disturb + 1) start = 1'b0;
            if (!cs_n) cslow++;
            if (busy !== !cs_n) busy_bad++;
            if (!prev_cs && sclk !== prev_sclk) begin
                edges++;
                if (sclk === ~(cp ^ ch)) begin
                    if (samp == 0) first_bit = mosi;
                    samp++;
                    mw = {mw[6:0], mosi};
                end
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                got_rx = rx_data;
                if (!(cs_n === 1'b1 && prev_cs === 1'b0)) coinc = 1'b0;
            end
            sub_miso = sub_bit(sw, edges, ch, lf);
            prev_sclk = sclk; prev_cs = cs_n;
        end
        for (int c = 0; c < 2 * (int'(dv) + 1) + 4; c++) begin
            @(posedge pclk); #1;
            if (cs_n !== 1'b1 || done !== 1'b0 || sclk !== cp || busy !== 1'b0)
                post_bad++;
        end
        exp_rx = lp ? tx : sw;
        exp_mw = lf ? rev8(tx) : tx;
        checks++;
        if (got_done !== 1'b1) begin
            errors++; $display("FAIL %s done_seen: got %0b expected 1", tag, got_done);
        end
        checks++;
        if (idle_ok !== 1'b1) begin
            errors++; $display("FAIL %s setup_sclk_cs: got sclk=%0b cs_n=%0b expected sclk=%0b cs_n=0", tag, sclk, cs_n, cp);
        end
        checks++;
        if (cslow != exp_low) begin
            errors++; $display("FAIL %s cs_low_cycles: got %0d expected %0d", tag, cslow, exp_low);
        end
        checks++;
        if (coinc !== 1'b1) begin
            errors++; $display("FAIL %s done_with_cs_rise: got 0 expected 1", tag);
        end
        checks++;
        if (got_rx !== exp_rx) begin
            errors++; $display("FAIL %s rx_data: got %02h expected %02h", tag, got_rx, exp_rx);
        end
        checks++;
        if (mw !== exp_mw) begin
            errors++; $display("FAIL %s mosi_bits: got %02h expected %02h", tag, mw, exp_mw);
        end
        checks++;
        if (first_bit !== (lf ? tx[0] : tx[7])) begin
            errors++; $display("FAIL %s mosi_first: got %0b expected %0b", tag, first_bit, lf ? tx[0] : tx[7]);
        end
        checks++;
        if (samp != 8 || edges != 16) begin
            errors++; $display("FAIL %s sclk_edges: got %0d/%0d expected 8/16", tag, samp, edges);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++; $display("FAIL %s busy_vs_cs: got %0d bad cycles expected 0", tag, busy_bad);
        end
        checks++;
        if (post_bad != 0) begin
            errors++; $display("FAIL %s idle_after: got %0d bad cycles expected 0", tag, post_bad);
        end
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (2) @(negedge pclk);
        checks++;
        if ({cs_n, sclk, busy, done, mosi, rx_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_values: got cs_n=%0b sclk=%0b busy=%0b done=%0b mosi=%0b rx=%02h expected 1 0 0 0 0 00",
                     cs_n, sclk, busy, done, mosi, rx_data);
        end
        preset = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        checks++;
        if (cs_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got cs_n=%0b busy=%0b done=%0b expected 1 0 0", cs_n, busy, done);
        end
    endtask

    task automatic test_mode0();
        test_transfer(8'hA5, 1'b0, 1'b0, 8'd1, 8'h3C, 1'b0, 1'b0, -1, "mode0_a5");
    endtask

    task automatic test_modes();
        logic [1:0] m;
        for (int i = 1; i < 4; i++) begin
            m = 2'(i);
            test_transfer(8'h81, m[1], m[0], 8'd0, 8'h00, 1'b1, 1'b0, -1,
                          $sformatf("mode%0d_loop", i));
        end
    endtask

    task automatic test_back_to_back();
        int dones, falls, gap, busy_low, dbl;
        logic prev_cs, prev_done, fin;
        logic [7:0] tx;
        dones = 0; falls = 0; gap = 0; busy_low = 0; dbl = 0; fin = 1'b0;
        tx = 8'($urandom);
        @(negedge pclk);
        tx_data = tx; cpol = 1'b0; cpha = 1'b0; clk_div = 8'd2;
        lsb_first = 1'b0; loop_en = 1'b1; start = 1'b1;
        prev_cs = cs_n; prev_done = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(posedge pclk); #1;
            if (prev_cs === 1'b1 && cs_n === 1'b0) begin
                falls++;
                if (falls == 2) start = 1'b0;
            end
            if (done === 1'b1) begin
                dones++;
                if (prev_done) dbl++;
            end
            if (dones == 1 && falls == 1 && cs_n === 1'b1) gap++;
            if (falls == 1 && busy === 1'b0) busy_low++;
            if (dones == 2) fin = 1'b1;
            prev_cs = cs_n; prev_done = done;
        end
        start = 1'b0;
        repeat (12) @(posedge pclk);
        checks++;
        if (dones != 2) begin
            errors++; $display("FAIL b2b_dones: got %0d expected 2", dones);
        end
        checks++;
        if (gap != 1) begin
            errors++; $display("FAIL b2b_cs_gap: got %0d expected 1", gap);
        end
        checks++;
        if (busy_low != 1) begin
            errors++; $display("FAIL b2b_busy_low: got %0d expected 1", busy_low);
        end
        checks++;
        if (dbl != 0) begin
            errors++; $display("FAIL b2b_done_width: got %0d long pulses expected 0", dbl);
        end
        checks++;
        if (rx_data !== tx) begin
            errors++; $display("FAIL b2b_rx: got %02h expected %02h", rx_data, tx);
        end
    endtask

    task automatic test_ignore_start();
        test_transfer(8'hA5, 1'b0, 1'b0, 8'd1, 8'h5A, 1'b0, 1'b0, 10, "ignore_start");
    endtask

    task automatic test_reset_mid();
        int edges, dones;
        logic prev_sclk, prev_cs, hit;
        edges = 0; dones = 0; hit = 1'b0;
        @(negedge pclk);
        tx_data = 8'($urandom); cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1;
        lsb_first = 1'b0; loop_en = 1'b1; start = 1'b1;
        prev_sclk = sclk; prev_cs = cs_n;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(posedge pclk); #1;
            start = 1'b0;
            if (!prev_cs && sclk !== prev_sclk) edges++;
            if (edges == 7) hit = 1'b1;
            prev_sclk = sclk; prev_cs = cs_n;
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL rst_mid_reach_edge7: got %0d edges expected 7", edges);
        end
        preset = 1'b1;
        #1;
        checks++;
        if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got cs_n=%0b sclk=%0b busy=%0b done=%0b expected 1 0 0 0",
                     cs_n, sclk, busy, done);
        end
        repeat (2) @(negedge pclk);
        preset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge pclk); #1;
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL rst_mid_no_done: got %0d expected 0", dones);
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++; $display("FAIL rst_mid_rx: got %02h expected 00", rx_data);
        end
        test_transfer(8'h3C, 1'b0, 1'b0, 8'd1, 8'hC3, 1'b0, 1'b0, -1, "after_reset");
    endtask

    task automatic test_random();
        logic [7:0] tx, sw, dv;
        logic cp, ch, lp;
        for (int i = 0; i < 8; i++) begin
            tx = 8'($urandom); sw = 8'($urandom);
            dv = 8'($urandom_range(0, 3));
            cp = 1'($urandom_range(0, 1));
            ch = 1'($urandom_range(0, 1));
            lp = 1'($urandom_range(0, 1));
            test_transfer(tx, cp, ch, dv, sw, lp, 1'b0, -1, $sformatf("rand%0d", i));
        end
    endtask

`ifdef SPI_MAIN_LSB_FIRST_EN
    task automatic test_lsb_first();
        test_transfer(8'h01, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 1'b1, -1, "lsb_loop");
        for (int i = 0; i < 4; i++) begin
            test_transfer(8'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 8'($urandom_range(0, 2)),
                          8'($urandom), 1'b0, 1'b1, -1, $sformatf("lsb_rand%0d", i));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_random();
`ifdef SPI_MAIN_LSB_FIRST_EN
        test_lsb_first();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
